// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline-stage register carrying a control and a data bundle.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid buffer with a registered in_ready.
module pipe_stage_elastic #(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 208,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_bubble,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              main_vld;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;
   logic              accept, issue;
   logic [CTRL_W-1:0] acc_ctrl;

   assign accept   = in_valid & in_ready;
   assign issue    = main_vld & out_ready;
   assign acc_ctrl = in_bubble ? '0 : in_ctrl;

`ifdef PIPE_STAGE_SKID_EN
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   state_t            state, state_nxt;
   logic              rdy_q;
   logic              ld_main_in, ld_main_skid, ld_skid;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;

   always_comb begin
      state_nxt    = state;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      case (state)
         EMPTY: if (accept) begin
            ld_main_in = 1'b1;
            state_nxt  = ONE;
         end
         ONE: begin
            if (accept && issue) begin
               ld_main_in = 1'b1;
            end else if (accept) begin
               ld_skid   = 1'b1;
               state_nxt = TWO;
            end else if (issue) begin
               state_nxt = EMPTY;
            end
         end
         TWO: if (issue) begin
            ld_main_skid = 1'b1;
            state_nxt    = ONE;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // in_ready is a flop so the upstream never sees a path from out_ready.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= EMPTY;
         rdy_q     <= 1'b0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else if (flush) begin
         state <= EMPTY;
         rdy_q <= 1'b1;
      end else begin
         state <= state_nxt;
         rdy_q <= (state_nxt != TWO);
         if (ld_skid) begin
            skid_ctrl <= acc_ctrl;
            skid_data <= in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         main_ctrl <= '0;
         main_data <= '0;
      end else if (!flush) begin
         if (ld_main_in) begin
            main_ctrl <= acc_ctrl;
            main_data <= in_data;
         end else if (ld_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
         end
      end
   end

   assign main_vld  = (state != EMPTY);
   assign in_ready  = rdy_q;
   assign occupancy = 2'(state);
`else
   always_ff @(posedge clk) begin
      if (!reset) begin
         main_vld  <= 1'b0;
         main_ctrl <= '0;
         main_data <= '0;
      end else if (flush) begin
         main_vld <= 1'b0;
      end else if (accept) begin
         main_vld  <= 1'b1;
         main_ctrl <= acc_ctrl;
         main_data <= in_data;
      end else if (issue) begin
         main_vld <= 1'b0;
      end
   end

   assign in_ready  = reset & (~main_vld | out_ready);
   assign occupancy = {1'b0, main_vld};
`endif

   always_ff @(posedge clk) begin
      if (!reset)
         stall_cnt <= '0;
      else if (!flush && main_vld && !out_ready && stall_cnt != {CNT_W{1'b1}})
         stall_cnt <= stall_cnt + 1'b1;
   end

   // Data holds its last value when empty; ctrl is masked so downstream sees no stray controls.
   assign out_valid = main_vld;
   assign out_ctrl  = main_vld ? main_ctrl : '0;
   assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Randomised and directed bench for pipe_stage_elastic against a FIFO-queue reference model.
module tb_pipe_stage_elastic;
   localparam int CW = 16;
   localparam int DW = 208;
   localparam int NW = 4;
`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, in_bubble, out_ready;
   logic          in_ready, out_valid;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [DW-1:0] in_data, out_data;
   logic [1:0]    occupancy;
   logic [NW-1:0] stall_cnt;

   pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_bubble(in_bubble),
      .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_data(out_data),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct { logic [CW-1:0] c; logic [DW-1:0] d; } ent_t;

   // Reference model: an ordered queue of held entries plus a few scalars.
   ent_t          q[$];
   bit            m_rdy = 1'b0;
   int            m_stall = 0;
   logic [DW-1:0] m_last = '0;
   logic          e_valid;
   logic [CW-1:0] e_ctrl;
   logic [DW-1:0] e_data;
   int            e_occ;
   int            vectors = 0;
   int            miscompares = 0;

   function automatic bit exp_ready();
      if (SKID) return m_rdy;
      return reset && (q.size() == 0 || out_ready);
   endfunction

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] r = '0;
      for (int i = 0; i < DW; i += 32) r = (r << 32) | DW'($urandom);
      return r;
   endfunction

   task automatic tick();
      bit   acc, iss;
      ent_t e;
      @(posedge clk);
      acc = in_valid && exp_ready();
      iss = (q.size() > 0) && out_ready;
      if (!reset) begin
         q.delete(); m_stall = 0; m_last = '0; m_rdy = 1'b0;
      end else if (flush) begin
         q.delete(); m_rdy = 1'b1;
      end else begin
         if (q.size() > 0 && !out_ready && m_stall < (1 << NW) - 1) m_stall++;
         if (iss) void'(q.pop_front());
         if (acc) begin
            e.c = in_bubble ? '0 : in_ctrl;
            e.d = in_data;
            q.push_back(e);
         end
         m_rdy = (q.size() < 2);
      end
      if (q.size() > 0) m_last = q[0].d;
      e_valid = (q.size() > 0);
      e_ctrl  = e_valid ? q[0].c : '0;
      e_data  = m_last;
      e_occ   = q.size();
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d);
      in_valid = v; in_ctrl = c; in_data = d;
   endtask

   task automatic test_reset();
      reset = 1'b0; flush = 1'b0; in_bubble = 1'b0; out_ready = 1'b1;
      drive(1'b1, 16'hBEEF, rnd_data());
      for (int i = 0; i < 3; i++) tick();
      vectors++;
      if ({out_valid, in_ready, occupancy} !== 4'b0 || out_ctrl !== '0 || out_data !== '0 || stall_cnt !== '0) begin
         miscompares++;
         $display("FAIL reset: valid=%b rdy=%b occ=%0d ctrl=%h stall=%0d data_zero=%b, required all zero",
                  out_valid, in_ready, occupancy, out_ctrl, stall_cnt, out_data == '0);
      end
   endtask

   task automatic test_stream();
      reset = 1'b1; drive(1'b0, '0, '0);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, CW'(16'h0011 + i), rnd_data());
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_ctrl !== CW'(16'h0011 + i) || occupancy !== 2'd1) begin
            miscompares++;
            $display("FAIL stream[%0d]: valid=%b ctrl=%h occ=%0d, required 1 %h 1",
                     i, out_valid, out_ctrl, occupancy, CW'(16'h0011 + i));
         end
      end
      drive(1'b0, '0, '0);
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1'b1, 16'h00A1, rnd_data());
      tick();
      if (SKID) begin
         drive(1'b1, 16'h00B2, rnd_data());
         tick();
         vectors++;
         if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_full: occ=%0d rdy=%b, required 2 0", occupancy, in_ready);
         end
         drive(1'b1, 16'h00C3, rnd_data());
         for (int i = 0; i < 4; i++) tick();
         vectors++;
         if (stall_cnt !== NW'(5) || occupancy !== 2'd2 || out_ctrl !== 16'h00A1) begin
            miscompares++;
            $display("FAIL bp_stall: stall=%0d occ=%0d ctrl=%h, required 5 2 00a1", stall_cnt, occupancy, out_ctrl);
         end
         out_ready = 1'b1;
         tick();
         vectors++;
         if (out_ctrl !== 16'h00B2 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_drainB: ctrl=%h rdy=%b, required 00b2 1", out_ctrl, in_ready);
         end
         tick();
         vectors++;
         if (out_ctrl !== 16'h00C3 || occupancy !== 2'd1) begin
            miscompares++;
            $display("FAIL bp_drainC: ctrl=%h occ=%0d, required 00c3 1", out_ctrl, occupancy);
         end
      end else begin
         drive(1'b1, 16'h00B2, rnd_data());
         #1;
         vectors++;
         if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ns_rdy_low: rdy=%b, required 0", in_ready);
         end
         tick();
         vectors++;
         if (out_ctrl !== 16'h00A1 || stall_cnt !== NW'(1)) begin
            miscompares++;
            $display("FAIL ns_hold: ctrl=%h stall=%0d, required 00a1 1", out_ctrl, stall_cnt);
         end
         out_ready = 1'b1;
         #1;
         vectors++;
         if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ns_rdy_comb: rdy=%b, required 1", in_ready);
         end
         tick();
         vectors++;
         if (out_ctrl !== 16'h00B2 || occupancy !== 2'd1) begin
            miscompares++;
            $display("FAIL ns_reload: ctrl=%h occ=%0d, required 00b2 1", out_ctrl, occupancy);
         end
      end
      drive(1'b0, '0, '0);
      tick();
   endtask

   task automatic test_bubble();
      out_ready = 1'b1; in_bubble = 1'b1;
      drive(1'b1, 16'hFFFF, DW'(32'h1234));
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_ctrl !== 16'h0000 || out_data !== DW'(32'h1234)) begin
         miscompares++;
         $display("FAIL bubble: valid=%b ctrl=%h data_lo=%h, required 1 0000 1234", out_valid, out_ctrl, out_data[31:0]);
      end
      in_bubble = 1'b0;
      drive(1'b0, '0, '0);
      tick();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1'b1, 16'h0A0A, rnd_data()); tick();
      drive(1'b1, 16'h0B0B, rnd_data()); tick();
      flush = 1'b1;
      drive(1'b1, 16'h0F0F, rnd_data());
      tick();
      vectors++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0 || in_ready !== 1'b1 || int'(stall_cnt) !== m_stall) begin
         miscompares++;
         $display("FAIL flush: valid=%b ctrl=%h occ=%0d rdy=%b stall=%0d, required 0 0000 0 1 %0d",
                  out_valid, out_ctrl, occupancy, in_ready, stall_cnt, m_stall);
      end
      flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, '0, '0);
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_ghost[%0d]: valid=%b ctrl=%h, required 0", i, out_valid, out_ctrl);
         end
      end
   endtask

   task automatic test_saturate();
      out_ready = 1'b0;
      drive(1'b1, 16'h5A5A, rnd_data()); tick();
      drive(1'b0, '0, '0);
      for (int i = 0; i < 20; i++) tick();
      vectors++;
      if (stall_cnt !== NW'(15) || out_ctrl !== 16'h5A5A) begin
         miscompares++;
         $display("FAIL saturate: stall=%0d ctrl=%h, required 15 5a5a", stall_cnt, out_ctrl);
      end
      reset = 1'b0;
      drive(1'b1, 16'h1111, rnd_data());
      tick();
      vectors++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || occupancy !== 2'd0 || stall_cnt !== '0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset: valid=%b ctrl=%h occ=%0d stall=%0d rdy=%b, required all zero",
                  out_valid, out_ctrl, occupancy, stall_cnt, in_ready);
      end
      reset = 1'b1;
      drive(1'b0, '0, '0);
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         drive(($urandom_range(0, 99) < 65), CW'($urandom), rnd_data());
         in_bubble = ($urandom_range(0, 99) < 20);
         out_ready = ($urandom_range(0, 99) < 60);
         flush     = ($urandom_range(0, 99) < 3);
         #1;
         vectors++;
         if (in_ready !== exp_ready()) begin
            miscompares++;
            $display("FAIL rnd_ready[%0d]: got %b required %b", n, in_ready, exp_ready());
         end
         tick();
         vectors++;
         if (out_valid !== e_valid || out_ctrl !== e_ctrl || out_data !== e_data ||
             int'(occupancy) !== e_occ || int'(stall_cnt) !== m_stall) begin
            miscompares++;
            $display("FAIL rnd_out[%0d]: valid=%b ctrl=%h occ=%0d stall=%0d data_ok=%b, required %b %h %0d %0d",
                     n, out_valid, out_ctrl, occupancy, stall_cnt, out_data === e_data, e_valid, e_ctrl, e_occ, m_stall);
         end
      end
      flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_bubble();
      test_flush();
      test_saturate();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised elastic pipeline-stage register; successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a generic control bundle and a data bundle between two stages using a valid/ready handshake.
- Supports pipeline flush, bubble insertion (control zeroed, data kept) and stall accounting.
- Optional 2-entry skid buffer breaks the combinational ready path between stages.

Parameters:
CTRL_W, 16, width of control bundle (RegWrite, MemRead, ALUOp, ...); zeroed on bubble/flush
DATA_W, 208, width of data bundle (PC, operands, imm, rs1/rs2/rd)
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
flush  in  1  synchronous discard of all held entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle
in_bubble  in  1  qualifies the accepted entry: store it with ctrl forced to 0
in_ctrl  in  CTRL_W  control bundle
in_data  in  DATA_W  data bundle
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head
out_ctrl  out  CTRL_W  head control bundle; 0 whenever out_valid=0
out_data  out  DATA_W  head data bundle; holds last value when out_valid=0
occupancy  out  2  entries held (0..2 with SKID_EN, 0..1 without)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Clock/reset: one clock `clk`. Reset is synchronous, active-low: sampled on the rising edge of clk, reset=0 resets.
- Reset values while reset=0 and on the first edge after: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0, skid entry invalid/zero, in_ready=0 (forced, both modes).
- Handshakes: accept = in_valid & in_ready; issue = out_valid & out_ready. in_valid/in_ctrl/in_data are ignored when in_ready=0. Order is strictly FIFO; no entry is dropped or duplicated except by flush.
- Bubble: if accept & in_bubble, the stored ctrl is all-zero and data is stored unchanged. Entry is still valid and is counted in occupancy.
- Latency: an accepted entry appears at out_* on the next cycle if the stage was empty, or after the entries ahead of it issue.
- Priority: reset > flush > normal. On flush (reset=1): both entries invalidated, occupancy=0, out_ctrl=0, any same-cycle accept is discarded, stall_cnt unchanged, in_ready=1 next cycle.
- stall_cnt: +1 each cycle with out_valid=1 & out_ready=0 & flush=0. Holds at 2^CNT_W-1.
- FSM with SKID_EN, states EMPTY/ONE/TWO; occupancy = 0/1/2:
  - EMPTY: accept -> main loaded, ONE.
  - ONE: accept & issue -> main reloaded, ONE. accept only -> skid loaded, TWO. issue only -> EMPTY. Neither -> hold.
  - TWO: issue -> skid moves to main, ONE. No issue -> hold.
  - in_ready is registered: 1 iff next state != TWO. It is not a function of out_ready in the same cycle.
  - TWO with issue: in_ready rises one cycle later.

Optional Feature:
Macro PIPE_STAGE_SKID_EN.
- Defined: 2-entry skid FSM as above; in_ready is a flop output; throughput is 1/cycle under random out_ready.
- Undefined: single main register.
  - in_ready = reset & (~out_valid | out_ready), combinational from out_ready.
  - occupancy is 0 or 1 (bit 1 tied to 0).
  - accept & issue in the same cycle reloads main.
  - Flush, bubble, stall_cnt and reset behaviour are identical to the defined case.

Test Plan:
1. Reset/streaming: hold reset=0 for 3 cycles; check all outputs zero and in_ready=0. Release, then stream ctrl=0x0011..0x0015 with out_ready=1 -> out_ctrl 0x0011..0x0015 on consecutive cycles, one cycle behind input, occupancy=1 throughout.
2. Backpressure (SKID_EN): out_ready=0, send A (ctrl 0x00A1) then B (0x00B2) -> occupancy=2, in_ready=0 from the cycle after B. C held at input is not taken. After 5 stall cycles stall_cnt=5. Raise out_ready -> A, B, C issue in order, no loss.
3. Bubble: send ctrl=0xFFFF, data=0x1234 with in_bubble=1 -> out_valid=1, out_ctrl=0x0000, out_data=0x1234.
4. Flush with two entries held and an in_valid the same cycle -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; the flushed-cycle input never appears at the output.
5. Saturation: with CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15. Mid-stream reset=0 -> all state cleared on that edge.
6. Non-skid build: out_ready=0 with one entry held -> in_ready=0 in the same cycle. Toggle out_ready=1 -> in_ready=1 combinationally, and accept plus issue complete in one cycle.
